// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LOCK_C = 2'd1,
    LOCK_D = 2'd2
  } state_e;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie, grants the port that was not granted last.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_i == PORT_D) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one unified memory between the core port (C) and the debug/DMA port (D),
// round-robin with bounded burst locking and registered per-port read data.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic          c_lock,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_lock,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          c_rvalid_q, d_rvalid_q;
  logic [DW-1:0] c_rdata_q, d_rdata_q;
  logic [1:0]    pick_gnt;
  logic          gnt_c, gnt_d;

  rr_pick2 u_pick (
    .req_i  ({d_req, c_req}),
    .last_i (last_q),
    .gnt_o  (pick_gnt)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_c   = 1'b0;
    gnt_d   = 1'b0;
    case (state_q)
      ARB: begin
        gnt_c = pick_gnt[0];
        gnt_d = pick_gnt[1];
        // A one-beat burst limit never enters a lock state.
        if (gnt_c) begin
          last_d = PORT_C;
          if (c_lock && (MAX_BURST > 1)) begin
            state_d = LOCK_C;
            cnt_d   = CNT_ONE;
          end
        end else if (gnt_d) begin
          last_d = PORT_D;
          if (d_lock && (MAX_BURST > 1)) begin
            state_d = LOCK_D;
            cnt_d   = CNT_ONE;
          end
        end
      end
      LOCK_C: begin
        gnt_c = c_req;
        if (c_req) last_d = PORT_C;
        if (c_req && c_lock && (cnt_q != CNT_LAST)) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          state_d = ARB;
          cnt_d   = '0;
        end
      end
      LOCK_D: begin
        gnt_d = d_req;
        if (d_req) last_d = PORT_D;
        if (d_req && d_lock && (cnt_q != CNT_LAST)) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          state_d = ARB;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ARB;
        cnt_d   = '0;
      end
    endcase
  end

  // Grants are masked by reset so no write can reach memory while rst is low.
  assign c_gnt = gnt_c & rst;
  assign d_gnt = gnt_d & rst;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (c_gnt) begin
      mem_we   = c_we;
      mem_addr = c_addr;
      mem_wd   = c_wdata;
    end else if (d_gnt) begin
      mem_we   = d_we;
      mem_addr = d_addr;
      mem_wd   = d_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB;
      last_q     <= PORT_D;
      cnt_q      <= '0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      c_rvalid_q <= c_gnt & ~c_we;
      d_rvalid_q <= d_gnt & ~d_we;
      if (c_gnt && !c_we) c_rdata_q <= mem_rd;
      if (d_gnt && !d_we) d_rdata_q <= mem_rd;
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign c_rdata  = c_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: grant checks per scenario, read data via scoreboard queues.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          c_req, c_we, c_lock, d_req, d_we, d_lock;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata;
  logic          c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] c_rdata, d_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd, mem_rd;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  rd_t c_q[$];
  rd_t d_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'h1234, ~a[15:0]};
  endfunction

  assign mem_rd = exp_rd(mem_addr);

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Scoreboard monitor: each pushed read must return exactly on its due cycle.
  always @(negedge clk) begin
    if (c_rvalid) begin
      checks++;
      if (c_q.size() == 0 || c_q[0].due != cyc) begin
        failures++;
        $display("FAIL c_rvalid_unexpected cyc=%0d rdata=%h required no rvalid", cyc, c_rdata);
      end else begin
        if (c_rdata !== c_q[0].data) begin
          failures++;
          $display("FAIL c_rdata cyc=%0d got=%h required=%h", cyc, c_rdata, c_q[0].data);
        end
        void'(c_q.pop_front());
      end
    end else if (c_q.size() > 0 && c_q[0].due == cyc) begin
      checks++;
      failures++;
      $display("FAIL c_rvalid_missing cyc=%0d got=0 required=1", cyc);
      void'(c_q.pop_front());
    end
    if (d_rvalid) begin
      checks++;
      if (d_q.size() == 0 || d_q[0].due != cyc) begin
        failures++;
        $display("FAIL d_rvalid_unexpected cyc=%0d rdata=%h required no rvalid", cyc, d_rdata);
      end else begin
        if (d_rdata !== d_q[0].data) begin
          failures++;
          $display("FAIL d_rdata cyc=%0d got=%h required=%h", cyc, d_rdata, d_q[0].data);
        end
        void'(d_q.pop_front());
      end
    end else if (d_q.size() > 0 && d_q[0].due == cyc) begin
      checks++;
      failures++;
      $display("FAIL d_rvalid_missing cyc=%0d got=0 required=1", cyc);
      void'(d_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_c(input logic [31:0] a);
    c_q.push_back('{cyc + 1, exp_rd(a)});
    $display("txn cyc=%0d port=C read addr=%h", cyc, a);
  endtask

  task automatic push_d(input logic [31:0] a);
    d_q.push_back('{cyc + 1, exp_rd(a)});
    $display("txn cyc=%0d port=D read addr=%h", cyc, a);
  endtask

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_lock = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_lock = 0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 0;
    c_req = 1; c_we = 1; c_addr = 32'h4; c_wdata = 32'h1111;
    d_req = 1; d_we = 1; d_addr = 32'h8; d_wdata = 32'h2222;
    tick(); tick();
    @(negedge clk);
    checks++;
    if (c_gnt !== 1'b0 || d_gnt !== 1'b0) begin
      failures++;
      $display("FAIL reset_gnt got c=%b d=%b required c=0 d=0", c_gnt, d_gnt);
    end
    checks++;
    if (mem_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_mem_we got=%b required=0", mem_we);
    end
    checks++;
    if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0 || c_rdata !== '0 || d_rdata !== '0) begin
      failures++;
      $display("FAIL reset_rsp got rv=%b%b c=%h d=%h required 00/0/0", c_rvalid, d_rvalid, c_rdata, d_rdata);
    end
    @(posedge clk); #1;
    rst = 1;
    c_we = 0; c_addr = 32'h40;
    d_we = 0; d_addr = 32'h44;
    @(negedge clk);
    checks++;
    if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_tie got c=%b d=%b required c=1 d=0", c_gnt, d_gnt);
    end
    push_c(32'h40);
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_single_read();
    c_req = 1; c_we = 0; c_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (c_gnt !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL single_gnt got gnt=%b addr=%h we=%b required 1/10/0", c_gnt, mem_addr, mem_we);
    end
    push_c(32'h10);
    tick();
    c_req = 0;
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL single_d_rvalid got=%b required=0", d_rvalid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (c_rdata !== 32'hDEADBEEF || c_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL single_hold got rdata=%h rv=%b required DEADBEEF/0", c_rdata, c_rvalid);
    end
    tick();
  endtask

  task automatic test_burst_lock();
    c_req = 1; c_we = 0; c_addr = 32'h400;
    d_req = 1; d_we = 0; d_lock = 1;
    for (int i = 0; i < MB; i++) begin
      d_addr = 32'h300 + 32'(4 * i);
      @(negedge clk);
      checks++;
      if (d_gnt !== 1'b1 || c_gnt !== 1'b0) begin
        failures++;
        $display("FAIL burst_beat%0d got c=%b d=%b required c=0 d=1", i + 1, c_gnt, d_gnt);
      end
      push_d(d_addr);
      tick();
    end
    d_addr = 32'h320;
    @(negedge clk);
    checks++;
    if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      failures++;
      $display("FAIL burst_release got c=%b d=%b required c=1 d=0", c_gnt, d_gnt);
    end
    push_c(32'h400);
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_write();
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h5A5A5A5A;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wd !== 32'h5A5A5A5A) begin
      failures++;
      $display("FAIL write_mux got gnt=%b we=%b addr=%h wd=%h required 1/1/20/5A5A5A5A",
               d_gnt, mem_we, mem_addr, mem_wd);
    end
    $display("txn cyc=%0d port=D write addr=20 data=5A5A5A5A", cyc);
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b0 || d_rdata !== exp_rd(32'h31C)) begin
      failures++;
      $display("FAIL write_no_rsp got rv=%b rdata=%h required 0/%h", d_rvalid, d_rdata, exp_rd(32'h31C));
    end
    tick();
  endtask

  task automatic test_contention();
    logic exp_d;
    exp_d = 1'b0;
    c_req = 1; c_addr = 32'h100;
    d_req = 1; d_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (c_gnt !== !exp_d || d_gnt !== exp_d) begin
        failures++;
        $display("FAIL contention_%0d got c=%b d=%b required c=%b d=%b", i, c_gnt, d_gnt, !exp_d, exp_d);
      end
      if (exp_d) push_d(32'h200); else push_c(32'h100);
      exp_d = !exp_d;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_early_release();
    c_req = 1; c_lock = 1;
    d_req = 1; d_addr = 32'h600;
    for (int i = 0; i < 5; i++) begin
      c_addr = 32'h500 + 32'(4 * i);
      if (i == 3) c_lock = 0;
      @(negedge clk);
      checks++;
      if (i < 4) begin
        if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin
          failures++;
          $display("FAIL early_rel_%0d got c=%b d=%b required c=1 d=0", i + 1, c_gnt, d_gnt);
        end
        push_c(c_addr);
      end else begin
        if (c_gnt !== 1'b0 || d_gnt !== 1'b1) begin
          failures++;
          $display("FAIL early_rel_%0d got c=%b d=%b required c=0 d=1", i + 1, c_gnt, d_gnt);
        end
        push_d(32'h600);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    d_req = 1; d_lock = 1; d_we = 0;
    for (int i = 0; i < 2; i++) begin
      d_addr = 32'h700 + 32'(4 * i);
      @(negedge clk);
      checks++;
      if (d_gnt !== 1'b1) begin
        failures++;
        $display("FAIL midrst_beat%0d got d=%b required 1", i + 1, d_gnt);
      end
      push_d(d_addr);
      tick();
    end
    d_we = 1; d_addr = 32'h708; d_wdata = 32'h12345678;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || mem_we !== 1'b1) begin
      failures++;
      $display("FAIL midrst_beat3 got gnt=%b we=%b required 1/1", d_gnt, mem_we);
    end
    #2;
    rst = 0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || d_gnt !== 1'b0 || c_gnt !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async got we=%b c=%b d=%b required 0/0/0", mem_we, c_gnt, d_gnt);
    end
    checks++;
    if (d_rvalid !== 1'b0 || d_rdata !== '0 || c_rdata !== '0) begin
      failures++;
      $display("FAIL midrst_clear got rv=%b d=%h c=%h required 0/0/0", d_rvalid, d_rdata, c_rdata);
    end
    c_q.delete();
    d_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
    c_req = 1; c_we = 0; c_addr = 32'h800;
    d_req = 1; d_we = 0; d_lock = 1; d_addr = 32'h804;
    @(negedge clk);
    checks++;
    if (c_gnt !== 1'b1 || d_gnt !== 1'b0 || d_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_after got c=%b d=%b drv=%b required 1/0/0", c_gnt, d_gnt, d_rvalid);
    end
    push_c(32'h800);
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_no_rvalid got=%b required=0", d_rvalid);
    end
    tick();
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    test_reset();
    test_single_read();
    test_burst_lock();
    test_write();
    test_contention();
    test_early_release();
    test_reset_mid_burst();
    tick(); tick();
    checks++;
    if (c_q.size() != 0 || d_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got c=%0d d=%0d pending required 0/0", c_q.size(), d_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
